gfx_bus_arbiter: RTL and testbench

GFX_BUS_ARBITER -- requirements
Module: gfx_bus_arbiter

---
 rtl/gfx_bus_arbiter_if.sv | 43 ++++
 rtl/gfx_bus_arbiter.sv | 117 +++++++++++
 tb/tb_gfx_bus_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/gfx_bus_arbiter_if.sv
// rtl/gfx_bus_arbiter_if.sv - requester handshakes and graphics register bus bundle
interface gfx_bus_arbiter_if #(
    parameter int ADDR_W = 4
);
    logic              rq0_valid;
    logic              rq0_write;
    logic [ADDR_W-1:0] rq0_addr;
    logic [15:0]       rq0_wdata;
    logic              rq0_ready;
    logic              rq0_err;

    logic              rq1_valid;
    logic              rq1_write;
    logic [ADDR_W-1:0] rq1_addr;
    logic [15:0]       rq1_wdata;
    logic              rq1_ready;
    logic              rq1_err;

    logic [15:0]       rdata;

    logic              gfx_cs;
    logic              gfx_read;
    logic [ADDR_W-1:0] gfx_addr;
    logic [15:0]       gfx_wdata;
    logic              gfx_oe;
    logic [15:0]       gfx_rdata;

    modport slave (
        input  rq0_valid, rq0_write, rq0_addr, rq0_wdata,
        input  rq1_valid, rq1_write, rq1_addr, rq1_wdata,
        output rq0_ready, rq0_err, rq1_ready, rq1_err, rdata,
        output gfx_cs, gfx_read, gfx_addr, gfx_wdata, gfx_oe,
        input  gfx_rdata
    );

    modport master (
        output rq0_valid, rq0_write, rq0_addr, rq0_wdata,
        output rq1_valid, rq1_write, rq1_addr, rq1_wdata,
        input  rq0_ready, rq0_err, rq1_ready, rq1_err, rdata,
        input  gfx_cs, gfx_read, gfx_addr, gfx_wdata, gfx_oe,
        output gfx_rdata
    );
endinterface

// File: rtl/gfx_bus_arbiter.sv
// rtl/gfx_bus_arbiter.sv - two-requester round-robin arbiter for the graphics register bus
module gfx_bus_arbiter #(
    parameter int NUM_REGS = 10,
    parameter int ADDR_W   = 4
) (
    input logic               clk,
    input logic               rst,
    gfx_bus_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_CAP, TURN} state_t;

    localparam logic [31:0] NUM_REGS_U = 32'(NUM_REGS);

    state_t            state;
    logic              last_grant;
    logic              owner;

    logic              grant_vld;
    logic              grant_id;
    logic              g_write;
    logic              g_bad;
    logic [ADDR_W-1:0] g_addr;
    logic [15:0]       g_wdata;

    always_comb begin
        grant_vld = bus.rq0_valid | bus.rq1_valid;
        if (bus.rq0_valid && bus.rq1_valid)
            grant_id = ~last_grant;
        else
            grant_id = bus.rq1_valid;
        g_write = grant_id ? bus.rq1_write : bus.rq0_write;
        g_addr  = grant_id ? bus.rq1_addr  : bus.rq0_addr;
        g_wdata = grant_id ? bus.rq1_wdata : bus.rq0_wdata;
        g_bad   = 32'(g_addr) >= NUM_REGS_U;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            owner         <= 1'b0;
            bus.rq0_ready <= 1'b0;
            bus.rq0_err   <= 1'b0;
            bus.rq1_ready <= 1'b0;
            bus.rq1_err   <= 1'b0;
            bus.rdata     <= 16'h0;
            bus.gfx_cs    <= 1'b0;
            bus.gfx_read  <= 1'b0;
            bus.gfx_addr  <= '0;
            bus.gfx_wdata <= 16'h0;
            bus.gfx_oe    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.rq0_ready <= 1'b0;
                    bus.rq1_ready <= 1'b0;
                    bus.rq0_err   <= 1'b0;
                    bus.rq1_err   <= 1'b0;
                    // An error response is issued from IDLE; skip arbitration while it is
                    // visible so the answered requester is not re-granted the same access.
                    if (grant_vld && !(bus.rq0_err || bus.rq1_err)) begin
                        last_grant   <= grant_id;
                        owner        <= grant_id;
                        bus.gfx_addr <= g_addr;
                        if (g_bad) begin
                            bus.rq0_ready <= ~grant_id;
                            bus.rq1_ready <= grant_id;
                            bus.rq0_err   <= ~grant_id;
                            bus.rq1_err   <= grant_id;
                        end else if (g_write) begin
                            state         <= WRITE;
                            bus.gfx_cs    <= 1'b1;
                            bus.gfx_oe    <= 1'b1;
                            bus.gfx_wdata <= g_wdata;
                            bus.rq0_ready <= ~grant_id;
                            bus.rq1_ready <= grant_id;
                        end else begin
                            state        <= RD_ISSUE;
                            bus.gfx_cs   <= 1'b1;
                            bus.gfx_read <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    state         <= IDLE;
                    bus.gfx_cs    <= 1'b0;
                    bus.gfx_oe    <= 1'b0;
                    bus.gfx_wdata <= 16'h0;
                    bus.rq0_ready <= 1'b0;
                    bus.rq1_ready <= 1'b0;
                end
                RD_ISSUE: begin
                    state        <= RD_WAIT;
                    bus.gfx_cs   <= 1'b0;
                    bus.gfx_read <= 1'b0;
                end
                RD_WAIT: begin
                    state         <= RD_CAP;
                    bus.rdata     <= bus.gfx_rdata;
                    bus.rq0_ready <= ~owner;
                    bus.rq1_ready <= owner;
                end
                RD_CAP: begin
                    state         <= TURN;
                    bus.rq0_ready <= 1'b0;
                    bus.rq1_ready <= 1'b0;
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gfx_bus_arbiter.sv
// tb/tb_gfx_bus_arbiter.sv - directed vector bench for gfx_bus_arbiter
module tb_gfx_bus_arbiter;
    localparam int ADDR_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    gfx_bus_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    gfx_bus_arbiter #(.NUM_REGS(10), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        v0;
        logic        w0;
        logic [3:0]  a0;
        logic [15:0] d0;
        logic        v1;
        logic        w1;
        logic [3:0]  a1;
        logic [15:0] d1;
        logic        exp_id;
        logic        exp_err;
        int          exp_lat;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [15:0] model_data(input logic [3:0] a);
        case (a)
            4'd6:    return 16'h01F4;
            4'd0:    return 16'h1234;
            default: return {12'h0A0, a};
        endcase
    endfunction

    // Graphics register file: data appears the cycle after a cs&read strobe
    logic [15:0] rd_model = 16'hBAD0;
    always @(posedge clk)
        rd_model <= (bus.gfx_cs && bus.gfx_read) ? model_data(bus.gfx_addr) : 16'hBAD0;
    assign bus.gfx_rdata = rd_model;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    logic prev_cs = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_cs = 1'b0;
        end else begin
            check("bus_oe_with_read", 32'(bus.gfx_oe & bus.gfx_read), 32'd0);
            check("bus_cs_consecutive", 32'(prev_cs & bus.gfx_cs), 32'd0);
            check("bus_wdata_undriven", 32'(!bus.gfx_oe && (bus.gfx_wdata != 16'h0)), 32'd0);
            prev_cs = bus.gfx_cs;
        end
    end

    task automatic drop_inputs();
        bus.rq0_valid = 1'b0; bus.rq0_write = 1'b0; bus.rq0_addr = 4'd0; bus.rq0_wdata = 16'h0;
        bus.rq1_valid = 1'b0; bus.rq1_write = 1'b0; bus.rq1_addr = 4'd0; bus.rq1_wdata = 16'h0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cs"},    32'(bus.gfx_cs),    32'd0);
        check({tag, "_read"},  32'(bus.gfx_read),  32'd0);
        check({tag, "_oe"},    32'(bus.gfx_oe),    32'd0);
        check({tag, "_addr"},  32'(bus.gfx_addr),  32'd0);
        check({tag, "_wdata"}, 32'(bus.gfx_wdata), 32'd0);
        check({tag, "_rdata"}, 32'(bus.rdata),     32'd0);
        check({tag, "_ready"}, 32'({bus.rq1_ready, bus.rq0_ready}), 32'd0);
        check({tag, "_err"},   32'({bus.rq1_err, bus.rq0_err}),     32'd0);
    endtask

    // Called at #1 after a rising edge with the arbiter idle; that cycle is the grant cycle.
    task automatic run_vec(input int idx, input vec_t v);
        int          k;
        int          cs_cnt;
        bit          got;
        logic [1:0]  rdy, err;
        logic [15:0] wd, rd;
        logic [3:0]  ad;
        logic        oe, wr;
        string       p;
        p = $sformatf("row%0d", idx);
        bus.rq0_valid = v.v0; bus.rq0_write = v.w0; bus.rq0_addr = v.a0; bus.rq0_wdata = v.d0;
        bus.rq1_valid = v.v1; bus.rq1_write = v.w1; bus.rq1_addr = v.a1; bus.rq1_wdata = v.d1;
        wr = v.exp_id ? v.w1 : v.w0;
        got = 0; k = 0; cs_cnt = 0;
        rdy = 2'b00; err = 2'b00; wd = 16'h0; rd = 16'h0; ad = 4'd0; oe = 1'b0;
        while (!got && k < 8) begin
            @(posedge clk); #1;
            k++;
            if (bus.gfx_cs) cs_cnt++;
            if (bus.rq0_ready || bus.rq1_ready) begin
                got = 1;
                rdy = {bus.rq1_ready, bus.rq0_ready};
                err = {bus.rq1_err, bus.rq0_err};
                wd = bus.gfx_wdata; ad = bus.gfx_addr; oe = bus.gfx_oe; rd = bus.rdata;
            end
        end
        drop_inputs();
        check({p, "_responded"}, 32'(got), 32'd1);
        if (got) begin
            check({p, "_ready_id"}, 32'(rdy), v.exp_id ? 32'd2 : 32'd1);
            check({p, "_err"}, 32'(err), v.exp_err ? (v.exp_id ? 32'd2 : 32'd1) : 32'd0);
            check({p, "_latency"}, 32'(k), 32'(v.exp_lat));
            check({p, "_cs_cycles"}, 32'(cs_cnt), v.exp_err ? 32'd0 : 32'd1);
            if (!v.exp_err && wr) begin
                check({p, "_wdata"}, 32'(wd), 32'(v.exp_data));
                check({p, "_addr"}, 32'(ad), 32'(v.exp_id ? v.a1 : v.a0));
                check({p, "_oe"}, 32'(oe), 32'd1);
            end else if (!v.exp_err) begin
                check({p, "_rdata"}, 32'(rd), 32'(v.exp_data));
            end
        end
        @(posedge clk); #1;
        if (!v.exp_err && !wr) begin
            check({p, "_turn_oe_cs"}, 32'({bus.gfx_oe, bus.gfx_cs}), 32'd0);
            check({p, "_turn_ready"}, 32'({bus.rq1_ready, bus.rq0_ready}), 32'd0);
        end
        @(posedge clk); #1;
    endtask

    int         seq [$];
    int         first_cyc;
    logic [1:0] r;

    initial begin
        //          v0 w0 a0     d0        v1 w1 a1     d1        id err lat data
        vecs[0] = '{1, 1, 4'd4,  16'h0140, 0, 0, 4'd0,  16'h0000, 0, 0,  1, 16'h0140};
        vecs[1] = '{0, 0, 4'd0,  16'h0000, 1, 0, 4'd6,  16'h0000, 1, 0,  3, 16'h01F4};
        vecs[2] = '{1, 1, 4'd1,  16'h1111, 1, 1, 4'd2,  16'h2222, 0, 0,  1, 16'h1111};
        vecs[3] = '{1, 1, 4'd1,  16'h1111, 1, 1, 4'd2,  16'h2222, 1, 0,  1, 16'h2222};
        vecs[4] = '{1, 1, 4'd12, 16'hBEEF, 0, 0, 4'd0,  16'h0000, 0, 1,  1, 16'h0000};
        vecs[5] = '{0, 0, 4'd0,  16'h0000, 1, 0, 4'd9,  16'h0000, 1, 0,  3, 16'h0A09};
        vecs[6] = '{1, 0, 4'd10, 16'h0000, 0, 0, 4'd0,  16'h0000, 0, 1,  1, 16'h0000};
        vecs[7] = '{1, 0, 4'd3,  16'h0000, 1, 1, 4'd15, 16'h5555, 1, 1,  1, 16'h0000};
        vecs[8] = '{1, 0, 4'd3,  16'h0000, 1, 0, 4'd5,  16'h0000, 0, 0,  3, 16'h0A03};

        drop_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Reset during RD_WAIT: outputs clear at once, the read is never answered
        bus.rq0_valid = 1'b1; bus.rq0_write = 1'b0; bus.rq0_addr = 4'd2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midrd_wait_cs", 32'(bus.gfx_cs), 32'd0);
        check("midrd_rdata_before", 32'(bus.rdata), 32'h0A03);
        #2 rst = 1'b0;
        #1 check_all_zero("midrd_async");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("midrd_no_ready", 32'({bus.rq1_ready, bus.rq0_ready}), 32'd0);
        end
        drop_inputs();
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        run_vec(9, '{1, 0, 4'd0, 16'h0000, 0, 0, 4'd0, 16'h0000, 0, 0, 3, 16'h1234});

        // Both requesters hold writes across reset release; grants must alternate from rq0
        rst = 1'b0;
        bus.rq0_valid = 1'b1; bus.rq0_write = 1'b1; bus.rq0_addr = 4'd1; bus.rq0_wdata = 16'hA000;
        bus.rq1_valid = 1'b1; bus.rq1_write = 1'b1; bus.rq1_addr = 4'd2; bus.rq1_wdata = 16'hB000;
        @(negedge clk); rst = 1'b1;
        first_cyc = -1;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            r = {bus.rq1_ready, bus.rq0_ready};
            if (r == 2'b11) check("cont_both_ready", 32'(r), 32'd1);
            if (r != 2'b00) begin
                if (first_cyc < 0) first_cyc = c;
                seq.push_back(r[1] ? 1 : 0);
                check($sformatf("cont_wdata%0d", seq.size()), 32'(bus.gfx_wdata),
                      r[1] ? 32'hB000 : 32'hA000);
            end
        end
        drop_inputs();
        check("cont_first_cycle", 32'(first_cyc), 32'd1);
        check("cont_count", 32'(seq.size()), 32'd8);
        for (int i = 0; i < seq.size(); i++)
            check($sformatf("cont_order%0d", i), 32'(seq[i]), 32'(i % 2));
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
